// File: rtl/rf_access_arbiter_pkg.sv
// ============================================================================
// rf_access_arbiter_pkg : shared state, command and reserved-address defs
// Revision 1.0
// ============================================================================
`default_nettype none

package rf_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic CMD_READ   = 1'b0;
    localparam logic CMD_WRITE  = 1'b1;
    localparam logic OWNER_REQ0 = 1'b0;
    localparam logic OWNER_REQ1 = 1'b1;

    // Highest register address reserved for the system controller.
    localparam int unsigned RF_PROT_ADDR_MAX = 3;

    function automatic logic wr_blocked(input logic        owner,
                                        input logic        wr,
                                        input int unsigned addr,
                                        input int unsigned prot_max);
        return (owner == OWNER_REQ1) && (wr == CMD_WRITE) && (addr <= prot_max);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_access_arbiter_rr_arb2.sv
// ============================================================================
// rf_access_arbiter_rr_arb2 : 2-way round-robin picker with last-grant register
// Revision 1.0
// ============================================================================
`default_nettype none

module rf_access_arbiter_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // last_q = 1 means Req1 won last, so a tie goes to Req0.
    logic last_q, last_d;

    assign gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
    assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);

    always_comb begin
        last_d = last_q;
        if (accept_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_access_arbiter.sv
// ============================================================================
// rf_access_arbiter : round-robin sharing of the single-port register file
// Revision 1.0
// ============================================================================
`default_nettype none

module rf_access_arbiter
    import rf_access_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned TIMEOUT       = 16,
    parameter int unsigned PROT_ADDR_MAX = RF_PROT_ADDR_MAX
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_REQ0,
    input  logic                  i_REQ1,
    input  logic                  i_WR0,
    input  logic                  i_WR1,
    input  logic [ADDR_WIDTH-1:0] i_ADDR0,
    input  logic [ADDR_WIDTH-1:0] i_ADDR1,
    input  logic [DATA_WIDTH-1:0] i_WDATA0,
    input  logic [DATA_WIDTH-1:0] i_WDATA1,
    output logic                  o_ACK0,
    output logic                  o_ACK1,
    output logic                  o_ERR,
    output logic [DATA_WIDTH-1:0] o_RDATA,
    output logic                  o_WrEn,
    output logic                  o_RdEn,
    output logic [ADDR_WIDTH-1:0] o_Address,
    output logic [DATA_WIDTH-1:0] o_WrData,
    input  logic [DATA_WIDTH-1:0] i_RdData,
    input  logic                  i_RdData_Valid
);

    localparam int unsigned            CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [1:0]            gnt;
    logic                  grant_en;
    logic                  blocked;

    assign grant_en = (state_q == ST_IDLE);
    assign blocked  = wr_blocked(owner_q, wr_q, 32'(addr_q), PROT_ADDR_MAX);

    rf_access_arbiter_rr_arb2 u_rr_arb2 (
        .clk_i    (i_CLK),
        .rst_ni   (i_RST),
        .req_i    ({i_REQ1, i_REQ0}),
        .accept_i (grant_en),
        .gnt_o    (gnt)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        o_ACK0    = 1'b0;
        o_ACK1    = 1'b0;
        o_ERR     = 1'b0;
        o_RDATA   = '0;
        o_WrEn    = 1'b0;
        o_RdEn    = 1'b0;
        o_Address = '0;
        o_WrData  = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d = gnt[1];
                    wr_d    = gnt[1] ? i_WR1    : i_WR0;
                    addr_d  = gnt[1] ? i_ADDR1  : i_ADDR0;
                    wdata_d = gnt[1] ? i_WDATA1 : i_WDATA0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = (wr_d == CMD_WRITE) ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                o_Address = addr_q;
                o_WrData  = wdata_q;
                if (blocked) begin
                    err_d = 1'b1;
                end else begin
                    o_WrEn = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_READ: begin
                o_RdEn    = 1'b1;
                o_Address = addr_q;
                cnt_d     = cnt_q + 1'b1;
                // Valid on the last allowed cycle still counts as success.
                if (i_RdData_Valid) begin
                    rdata_d = i_RdData;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_ACK0  = (owner_q == OWNER_REQ0);
                o_ACK1  = (owner_q == OWNER_REQ1);
                o_ERR   = err_q;
                o_RDATA = rdata_q;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_REQ0;
            wr_q    <= CMD_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_access_arbiter.sv
// ============================================================================
// tb_rf_access_arbiter : randomized scoreboard bench for rf_access_arbiter
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rf_access_arbiter;

    localparam int DW      = 8;
    localparam int AW      = 4;
    localparam int TIMEOUT = 16;
    localparam int PROT    = 3;

    typedef struct {
        bit          wr;
        bit [AW-1:0] addr;
        bit [DW-1:0] data;
        int          dly;   // RdEn cycle on which the RF answers; >TIMEOUT = never
    } txn_t;

    typedef struct {
        bit          owner;
        bit          err;
        bit [DW-1:0] rdata;
        bit          lat;   // an RF access precedes the ACK by exactly one cycle
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_REQ0, i_REQ1, i_WR0, i_WR1;
    logic [AW-1:0] i_ADDR0, i_ADDR1;
    logic [DW-1:0] i_WDATA0, i_WDATA1;
    logic          o_ACK0, o_ACK1, o_ERR;
    logic [DW-1:0] o_RDATA;
    logic          o_WrEn, o_RdEn;
    logic [AW-1:0] o_Address;
    logic [DW-1:0] o_WrData;
    logic [DW-1:0] i_RdData;
    logic          i_RdData_Valid;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_acc_cyc = 0;
    bit   last_gnt;
    exp_t ack_q[$];
    txn_t rf_q[$];
    bit [DW-1:0] ref_mem [16];
    bit [DW-1:0] rf_mem  [16];

    rf_access_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT), .PROT_ADDR_MAX(PROT)
    ) dut (
        .i_CLK(clk), .i_RST(rst_n),
        .i_REQ0(i_REQ0), .i_REQ1(i_REQ1), .i_WR0(i_WR0), .i_WR1(i_WR1),
        .i_ADDR0(i_ADDR0), .i_ADDR1(i_ADDR1), .i_WDATA0(i_WDATA0), .i_WDATA1(i_WDATA1),
        .o_ACK0(o_ACK0), .o_ACK1(o_ACK1), .o_ERR(o_ERR), .o_RDATA(o_RDATA),
        .o_WrEn(o_WrEn), .o_RdEn(o_RdEn), .o_Address(o_Address), .o_WrData(o_WrData),
        .i_RdData(i_RdData), .i_RdData_Valid(i_RdData_Valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input bit wr, input bit [AW-1:0] a, input bit [DW-1:0] d, input int dly);
        txn_t t;
        t.wr = wr; t.addr = a; t.data = d; t.dly = dly;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        int sel;
        txn_t t;
        sel    = int'($urandom_range(0, 9));
        t.wr   = 1'($urandom_range(0, 1));
        t.addr = AW'($urandom_range(0, 15));
        t.data = DW'($urandom);
        t.dly  = (sel < 6) ? int'($urandom_range(1, 6)) : (sel == 6) ? TIMEOUT :
                 (sel == 7) ? TIMEOUT - 1 : 40;
        return t;
    endfunction

    // Reference model: what one granted transaction must produce.
    task automatic model_issue(input bit owner, input txn_t t);
        exp_t e;
        e.owner = owner; e.err = 1'b0; e.rdata = '0; e.lat = 1'b1;
        if (t.wr) begin
            if (owner && (int'(t.addr) <= PROT)) begin
                e.err = 1'b1;
                e.lat = 1'b0;
            end else begin
                ref_mem[t.addr] = t.data;
                rf_q.push_back(t);
            end
        end else begin
            rf_q.push_back(t);
            if (t.dly <= TIMEOUT) e.rdata = ref_mem[t.addr];
            else                  e.err   = 1'b1;
        end
        ack_q.push_back(e);
        last_gnt = owner;
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic do_round(input bit u0, input bit u1, input txn_t t0, input txn_t t1);
        bit order[$];
        bit p0, p1;
        int guard;
        if (u0 && u1) begin
            if (last_gnt) begin order.push_back(1'b0); order.push_back(1'b1); end
            else          begin order.push_back(1'b1); order.push_back(1'b0); end
        end else if (u0) order.push_back(1'b0);
        else if (u1)     order.push_back(1'b1);
        foreach (order[k]) model_issue(order[k], order[k] ? t1 : t0);

        @(negedge clk);
        if (u0) begin i_REQ0 = 1'b1; i_WR0 = t0.wr; i_ADDR0 = t0.addr; i_WDATA0 = t0.data; end
        if (u1) begin i_REQ1 = 1'b1; i_WR1 = t1.wr; i_ADDR1 = t1.addr; i_WDATA1 = t1.data; end
        p0 = u0; p1 = u1; guard = 0;
        while ((p0 || p1) && guard < 200) begin
            @(negedge clk);
            guard++;
            if (p0 && o_ACK0) begin p0 = 1'b0; i_REQ0 = 1'b0; i_ADDR0 = '0; i_WDATA0 = '0; end
            if (p1 && o_ACK1) begin p1 = 1'b0; i_REQ1 = 1'b0; i_ADDR1 = '0; i_WDATA1 = '0; end
        end
        if (p0 || p1) begin
            n_checks++; n_fail++;
            $display("FAIL round_timeout: pending req0=%0d req1=%0d required none", p0, p1);
            finish_run();
        end
    endtask

    // RF responder: answers reads after the chosen delay and checks every access.
    int   rd_cnt = 0;
    txn_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cnt         = 0;
            i_RdData_Valid = 1'b0;
        end else begin
            if (o_WrEn || o_RdEn)
                check("wr_rd_exclusive", 32'({o_WrEn, o_RdEn} == 2'b11), 32'd0);
            if (o_WrEn) begin
                if (rf_q.size() == 0) check("unexpected_wren", 32'(o_Address), 32'hFFFF);
                else begin
                    cur = rf_q.pop_front();
                    check("rf_kind_wr", 32'({o_WrEn, o_RdEn}), cur.wr ? 32'd2 : 32'd1);
                    check("rf_wr_addr", 32'(o_Address), 32'(cur.addr));
                    check("rf_wr_data", 32'(o_WrData), 32'(cur.data));
                end
                rf_mem[o_Address] = o_WrData;
                last_acc_cyc = cyc;
            end
            if (o_RdEn) begin
                if (rd_cnt == 0) begin
                    if (rf_q.size() == 0) check("unexpected_rden", 32'(o_Address), 32'hFFFF);
                    else begin
                        cur = rf_q.pop_front();
                        check("rf_kind_rd", 32'({o_WrEn, o_RdEn}), cur.wr ? 32'd2 : 32'd1);
                        check("rf_rd_addr", 32'(o_Address), 32'(cur.addr));
                    end
                end
                rd_cnt++;
                last_acc_cyc   = cyc;
                i_RdData_Valid = (rd_cnt == cur.dly);
                i_RdData       = i_RdData_Valid ? rf_mem[o_Address] : DW'($urandom);
            end else begin
                if (rd_cnt > 0) begin
                    check("rden_cycles", 32'(rd_cnt), 32'((cur.dly <= TIMEOUT) ? cur.dly : TIMEOUT));
                    rd_cnt = 0;
                end
                // Stray valid pulses outside a read must be ignored.
                i_RdData_Valid = ($urandom_range(0, 3) == 0);
                i_RdData       = DW'($urandom);
            end
        end
    end

    // Completion monitor.
    exp_t e_mon;
    always @(negedge clk) begin
        if (rst_n && (o_ACK0 || o_ACK1)) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", 32'({o_ACK1, o_ACK0}), 32'd0);
            end else begin
                e_mon = ack_q.pop_front();
                check("ack_owner", 32'({o_ACK1, o_ACK0}), e_mon.owner ? 32'd2 : 32'd1);
                check("ack_err",   32'(o_ERR),   32'(e_mon.err));
                check("ack_rdata", 32'(o_RDATA), 32'(e_mon.rdata));
                if (e_mon.lat) check("ack_latency", 32'(cyc - last_acc_cyc), 32'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = DW'(i * 17 + 5);
            rf_mem[i]  = DW'(i * 17 + 5);
        end
        last_gnt = 1'b1;
        rst_n = 1'b0;
        i_REQ0 = 0; i_REQ1 = 0; i_WR0 = 0; i_WR1 = 0;
        i_ADDR0 = '0; i_ADDR1 = '0; i_WDATA0 = '0; i_WDATA1 = '0;
        i_RdData = '0; i_RdData_Valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({o_ACK0, o_ACK1, o_ERR, o_RDATA, o_WrEn, o_RdEn, o_Address, o_WrData}), 32'd0);
        rst_n = 1'b1;

        // Simultaneous reads after reset, twice: alternation from Req0.
        do_round(1, 1, mk(0, 4'd1, 8'h00, 2), mk(0, 4'd7, 8'h00, 2));
        do_round(1, 1, mk(0, 4'd9, 8'h00, 1), mk(0, 4'd2, 8'h00, 4));
        // Plain write, protected and unprotected Req1 writes, delayed read-back.
        do_round(1, 0, mk(1, 4'd5, 8'h3C, 1), mk(0, 4'd0, 8'h00, 1));
        do_round(0, 1, mk(0, 4'd0, 8'h00, 1), mk(1, 4'd2, 8'h11, 1));
        do_round(0, 1, mk(0, 4'd0, 8'h00, 1), mk(1, 4'd4, 8'h22, 1));
        do_round(1, 0, mk(0, 4'd5, 8'h00, 3), mk(0, 4'd0, 8'h00, 1));
        do_round(0, 1, mk(0, 4'd0, 8'h00, 1), mk(0, 4'd2, 8'h00, 3));
        // Timeout and valid exactly on the last allowed cycle.
        do_round(0, 1, mk(0, 4'd0, 8'h00, 1), mk(0, 4'd4, 8'h00, 40));
        do_round(1, 0, mk(0, 4'd4, 8'h00, TIMEOUT), mk(0, 4'd0, 8'h00, 1));

        // Reset in the middle of a read: outputs drop at once, no ACK.
        @(negedge clk);
        rf_q.push_back(mk(0, 4'd6, 8'h00, 40));
        i_REQ0 = 1'b1; i_WR0 = 1'b0; i_ADDR0 = 4'd6;
        repeat (4) @(negedge clk);
        check("rden_before_reset", 32'(o_RdEn), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_read", 32'({o_ACK0, o_ACK1, o_ERR, o_RDATA, o_WrEn, o_RdEn, o_Address, o_WrData}), 32'd0);
        i_REQ0 = 1'b0; i_ADDR0 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_gnt = 1'b1;
        do_round(1, 1, mk(1, 4'd8, 8'h5A, 1), mk(0, 4'd8, 8'h00, 2));

        for (int r = 0; r < 150; r++) begin
            int pat;
            pat = int'($urandom_range(0, 2));
            do_round(pat != 1, pat != 0, rnd_txn(), rnd_txn());
        end

        repeat (5) @(negedge clk);
        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        check("rf_queue_drained",  32'(rf_q.size()),  32'd0);
        finish_run();
    end

endmodule

`default_nettype wire
